// File: rtl/cube_pkg.sv
// Shared types, widths and the isometric-cube vertex/segment tables for cube_line_sched.
package cube_pkg;

    localparam int unsigned NSEG = 9;
    localparam int unsigned X_W  = 11;
    localparam int unsigned Y_W  = 10;
    localparam int unsigned B_W  = 12;

    typedef enum logic [2:0] {IDLE, CHECK, LAUNCH, DRAW, FINISH} state_t;

    typedef enum logic [2:0] {V0, V1, V2, V3, V4, V5, VC} vtx_t;

    // Segment k runs from SEG_A[k] to SEG_B[k]: hexagon outline, then the three inner spokes.
    localparam vtx_t SEG_A [NSEG] = '{V0, V1, V2, V3, V4, V5, VC, VC, VC};
    localparam vtx_t SEG_B [NSEG] = '{V1, V2, V3, V4, V5, V0, V1, V5, V3};

    function automatic logic [X_W-1:0] vtx_x(vtx_t v, logic [X_W-1:0] cx, logic [7:0] s);
        logic [X_W-1:0] se;
        se = X_W'(s);
        case (v)
            V1, V2:  vtx_x = cx + se;
            V4, V5:  vtx_x = cx - se;
            default: vtx_x = cx;
        endcase
    endfunction

    function automatic logic [Y_W-1:0] vtx_y(vtx_t v, logic [Y_W-1:0] cy, logic [7:0] s);
        logic [Y_W-1:0] se;
        logic [Y_W-1:0] he;
        se = Y_W'(s);
        he = Y_W'(s >> 1);
        case (v)
            V0:      vtx_y = cy - se;
            V1, V5:  vtx_y = cy - he;
            V2, V4:  vtx_y = cy + he;
            V3:      vtx_y = cy + se;
            default: vtx_y = cy;
        endcase
    endfunction

endpackage

// File: rtl/line_engine.sv
// Bresenham line stepper: one pixel per enabled cycle, done pulse after the last pixel is taken.
module line_engine
    import cube_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           en,
    input  logic [X_W-1:0] x0,
    input  logic [Y_W-1:0] y0,
    input  logic [X_W-1:0] x1,
    input  logic [Y_W-1:0] y1,
    output logic           plot,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           done
);

    logic [X_W-1:0]        x_end;
    logic [Y_W-1:0]        y_end;
    logic signed [B_W-1:0] dx, dy, err;
    logic                  sx, sy;

    logic signed [B_W-1:0] dx_init, dy_init;
    logic signed [B_W:0]   e2, dx_w, dy_w;
    logic                  step_x, step_y, at_end;

    always_comb begin
        dx_init = $signed(B_W'((x1 >= x0) ? (x1 - x0) : (x0 - x1)));
        dy_init = -$signed(B_W'((y1 >= y0) ? (y1 - y0) : (y0 - y1)));
        e2      = {err, 1'b0};
        dx_w    = {dx[B_W-1], dx};
        dy_w    = {dy[B_W-1], dy};
        step_x  = (e2 >= dy_w);
        step_y  = (e2 <= dx_w);
        at_end  = (x == x_end) && (y == y_end);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            plot  <= 1'b0;
            done  <= 1'b0;
            x     <= '0;
            y     <= '0;
            x_end <= '0;
            y_end <= '0;
            dx    <= '0;
            dy    <= '0;
            err   <= '0;
            sx    <= 1'b0;
            sy    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                x     <= x0;
                y     <= y0;
                x_end <= x1;
                y_end <= y1;
                dx    <= dx_init;
                dy    <= dy_init;
                err   <= dx_init + dy_init;
                sx    <= (x1 >= x0);
                sy    <= (y1 >= y0);
                plot  <= 1'b1;
            end else if (en && plot) begin
                if (at_end) begin
                    plot <= 1'b0;
                    done <= 1'b1;
                end else begin
                    if (step_x) x <= sx ? x + X_W'(1) : x - X_W'(1);
                    if (step_y) y <= sy ? y + Y_W'(1) : y - Y_W'(1);
                    err <= err + (step_x ? dy : '0) + (step_y ? dx : '0);
                end
            end
        end
    end

endmodule

// File: rtl/cube_line_sched.sv
// Sequences the nine line segments of an isometric cube through one line_engine.
module cube_line_sched
    import cube_pkg::*;
#(
    parameter int unsigned SCR_W = 800,
    parameter int unsigned SCR_H = 480
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           req,
    output logic           ack,
    input  logic [X_W-1:0] cx,
    input  logic [Y_W-1:0] cy,
    input  logic [7:0]     size,
    input  logic [7:0]     color,
    input  logic           abort,
    input  logic           pix_ready,
    output logic           plot,
    output logic [X_W-1:0] px,
    output logic [Y_W-1:0] py,
    output logic [7:0]     pcolor,
    output logic           busy,
    output logic           done,
    output logic           reject
);

    state_t         state, state_next;
    logic [3:0]     seg, seg_next;
    logic [X_W-1:0] cx_reg;
    logic [Y_W-1:0] cy_reg;
    logic [7:0]     s_reg, color_reg;
    logic           ack_next, done_next, reject_next, latch_en;

    logic           eng_start, eng_en, eng_plot, eng_done;
    logic [X_W-1:0] seg_x0, seg_x1;
    logic [Y_W-1:0] seg_y0, seg_y1;
    logic [B_W-1:0] bx, by, bs;
    logic           out_of_bounds;

    // Widened to 12 bits so cx+s and cy+s cannot wrap.
    always_comb begin
        bx = B_W'(cx_reg);
        by = B_W'(cy_reg);
        bs = B_W'(s_reg);
        out_of_bounds = (bx < bs) || ((bx + bs) > B_W'(SCR_W - 1)) ||
                        (by < bs) || ((by + bs) > B_W'(SCR_H - 1));
    end

    always_comb begin
        seg_x0 = vtx_x(SEG_A[seg], cx_reg, s_reg);
        seg_y0 = vtx_y(SEG_A[seg], cy_reg, s_reg);
        seg_x1 = vtx_x(SEG_B[seg], cx_reg, s_reg);
        seg_y1 = vtx_y(SEG_B[seg], cy_reg, s_reg);
    end

    always_comb begin
        state_next  = state;
        seg_next    = seg;
        ack_next    = 1'b0;
        done_next   = 1'b0;
        reject_next = 1'b0;
        eng_start   = 1'b0;
        latch_en    = 1'b0;
        unique case (state)
            IDLE: begin
                if (req) begin
                    ack_next   = 1'b1;
                    latch_en   = 1'b1;
                    state_next = CHECK;
                end
            end
            CHECK: begin
                if (out_of_bounds) begin
                    reject_next = 1'b1;
                    state_next  = IDLE;
                end else begin
                    seg_next   = '0;
                    state_next = LAUNCH;
                end
            end
            LAUNCH: begin
                eng_start  = 1'b1;
                state_next = DRAW;
            end
            DRAW: begin
                if (eng_done) begin
                    if (seg == 4'(NSEG - 1)) begin
                        state_next = FINISH;
                    end else begin
                        seg_next   = seg + 4'd1;
                        state_next = LAUNCH;
                    end
                end
            end
            FINISH: begin
                done_next  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (abort && (state != IDLE)) begin
            state_next  = IDLE;
            seg_next    = seg;
            done_next   = 1'b0;
            reject_next = 1'b0;
            eng_start   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            seg       <= '0;
            ack       <= 1'b0;
            done      <= 1'b0;
            reject    <= 1'b0;
            cx_reg    <= '0;
            cy_reg    <= '0;
            s_reg     <= '0;
            color_reg <= '0;
        end else begin
            state  <= state_next;
            seg    <= seg_next;
            ack    <= ack_next;
            done   <= done_next;
            reject <= reject_next;
            if (latch_en) begin
                cx_reg    <= cx;
                cy_reg    <= cy;
                s_reg     <= size;
                color_reg <= color;
            end
        end
    end

    // An aborted engine may still hold plot; gating by DRAW hides it until the next start.
    assign plot   = eng_plot && (state == DRAW);
    assign eng_en = pix_ready || !plot;
    assign busy   = (state != IDLE);
    assign pcolor = color_reg;

    line_engine u_line_engine (
        .clk   (clk),
        .reset (reset),
        .start (eng_start),
        .en    (eng_en),
        .x0    (seg_x0),
        .y0    (seg_y0),
        .x1    (seg_x1),
        .y1    (seg_y1),
        .plot  (eng_plot),
        .x     (px),
        .y     (py),
        .done  (eng_done)
    );

endmodule

// File: tb/tb_cube_line_sched.sv
// Randomised self-checking bench for cube_line_sched against a queue-based pixel model.
module tb_cube_line_sched;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        abort = 1'b0;
    logic        pix_ready = 1'b1;
    logic [10:0] cx = '0;
    logic [9:0]  cy = '0;
    logic [7:0]  size = '0;
    logic [7:0]  color = '0;
    logic        ack, plot, busy, done, reject;
    logic [10:0] px;
    logic [9:0]  py;
    logic [7:0]  pcolor;

    int          n_checks = 0;
    int          n_pass = 0;
    int          pix_cnt = 0;
    int          ack_cnt = 0;
    int          done_cnt = 0;
    int          rej_cnt = 0;
    int          rmode = 0;
    logic [28:0] first_pix, last_pix, prev_vals;
    bit          prev_stall = 1'b0;
    logic [28:0] exp_q[$];

    cube_line_sched #(.SCR_W(800), .SCR_H(480)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .ack       (ack),
        .cx        (cx),
        .cy        (cy),
        .size      (size),
        .color     (color),
        .abort     (abort),
        .pix_ready (pix_ready),
        .plot      (plot),
        .px        (px),
        .py        (py),
        .pcolor    (pcolor),
        .busy      (busy),
        .done      (done),
        .reject    (reject)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout, required $finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, got, exp);
    endtask

    function automatic logic [28:0] pix(input int x, input int y, input int c);
        return {11'(x), 10'(y), 8'(c)};
    endfunction

    // Reference: cube geometry plus textbook Bresenham, producing the full accepted-pixel stream.
    task automatic build(input int x, input int y, input int s, input int c,
                         output bit oob, output int n);
        int vx[7];
        int vy[7];
        int sa[9];
        int sb[9];
        int h, px0, py0, px1, py1, dx, dy, stx, sty, err, e2;
        h  = s / 2;
        vx = '{x, x + s, x + s, x, x - s, x - s, x};
        vy = '{y - s, y - h, y + h, y + s, y + h, y - h, y};
        sa = '{0, 1, 2, 3, 4, 5, 6, 6, 6};
        sb = '{1, 2, 3, 4, 5, 0, 1, 5, 3};
        exp_q.delete();
        n   = 0;
        oob = (x < s) || (x + s > 799) || (y < s) || (y + s > 479);
        if (oob) return;
        for (int k = 0; k < 9; k++) begin
            px0 = vx[sa[k]]; py0 = vy[sa[k]];
            px1 = vx[sb[k]]; py1 = vy[sb[k]];
            dx  = (px1 > px0) ? px1 - px0 : px0 - px1;
            dy  = (py1 > py0) ? py0 - py1 : py1 - py0;
            stx = (px1 >= px0) ? 1 : -1;
            sty = (py1 >= py0) ? 1 : -1;
            err = dx + dy;
            forever begin
                exp_q.push_back(pix(px0, py0, c));
                n++;
                if (px0 == px1 && py0 == py1) break;
                e2 = 2 * err;
                if (e2 >= dy) begin err += dy; px0 += stx; end
                if (e2 <= dx) begin err += dx; py0 += sty; end
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        case (rmode)
            1:       pix_ready = ~pix_ready;
            2:       pix_ready = 1'($urandom_range(0, 1));
            default: pix_ready = 1'b1;
        endcase
    end

    // Compare process: every accepted pixel against the model queue, plus hold-while-stalled.
    initial forever begin
        logic [31:0] e;
        logic [28:0] cur;
        @(negedge clk);
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            cur = {px, py, pcolor};
            if (ack) ack_cnt++;
            if (done) begin done_cnt++; check("busy_low_with_done", busy, 0); end
            if (reject) begin rej_cnt++; check("busy_low_with_reject", busy, 0); end
            if (plot) begin
                if (prev_stall) check("hold_while_stalled", cur, prev_vals);
                if (pix_ready) begin
                    e = (exp_q.size() > 0) ? {3'b0, exp_q.pop_front()} : 32'hFFFF_FFFF;
                    check("pixel", {3'b0, cur}, e);
                    if (pix_cnt == 0) first_pix = cur;
                    last_pix = cur;
                    pix_cnt++;
                end
            end
            prev_stall = plot && !pix_ready;
            prev_vals  = cur;
        end
    end

    task automatic start_req(input int x, input int y, input int s, input int c, input bit ab);
        @(negedge clk);
        cx = 11'(x); cy = 10'(y); size = 8'(s); color = 8'(c);
        pix_cnt = 0; ack_cnt = 0; rej_cnt = 0;
        req = 1'b1;
        abort = ab;
        @(negedge clk);
        check("ack_after_one_cycle", ack, 1);
        check("busy_after_ack", busy, 1);
        req = 1'b0;
        abort = 1'b0;
    endtask

    task automatic wait_done(input bit poke);
        bit got = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (poke && i == 30) req = 1'b1;
            if (poke && i == 34) req = 1'b0;
            if (done) begin got = 1'b1; break; end
        end
        req = 1'b0;
        check("done_seen", got, 1);
    endtask

    task automatic draw(input int x, input int y, input int s, input int c, input int mode,
                        input bit ab, input bit poke, output int n);
        bit oob;
        rmode = mode;
        build(x, y, s, c, oob, n);
        start_req(x, y, s, c, ab);
        @(negedge clk);
        check("reject_two_cycles_after_req", reject, 32'(oob));
        check("ack_one_cycle", ack, 0);
        if (oob) begin
            check("busy_after_reject", busy, 0);
            repeat (3) @(negedge clk);
            check("no_plot_on_reject", pix_cnt, 0);
            check("reject_count", rej_cnt, 1);
        end else begin
            check("busy_in_check", busy, 1);
            wait_done(poke);
            check("pixel_count", pix_cnt, n);
            check("queue_drained", exp_q.size(), 0);
            @(negedge clk);
            check("done_one_cycle", done, 0);
            check("ack_count", ack_cnt, 1);
        end
        rmode = 0;
    endtask

    task automatic wait_pix(input int target);
        bit got = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (pix_cnt >= target) begin got = 1'b1; break; end
        end
        check("reached_pixel_target", got, 1);
    endtask

    initial begin
        int n, d0, r0, p0;
        bit oob;
        #1;
        check("rst_ack", ack, 0);
        check("rst_plot", plot, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_reject", reject, 0);
        check("rst_px", px, 0);
        check("rst_py", py, 0);
        check("rst_pcolor", pcolor, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        draw(400, 240, 20, 8'hA5, 0, 1'b0, 1'b0, n);
        check("model_count_s20", n, 189);
        check("first_pixel", first_pix, pix(400, 220, 8'hA5));
        check("last_pixel", last_pix, pix(400, 260, 8'hA5));

        draw(10, 240, 20, 8'h11, 0, 1'b0, 1'b0, n);

        draw(100, 100, 0, 8'h3C, 0, 1'b0, 1'b0, n);
        check("model_count_s0", n, 9);
        check("s0_pixels", pix_cnt, 9);
        check("s0_first", first_pix, pix(100, 100, 8'h3C));
        check("s0_last", last_pix, pix(100, 100, 8'h3C));

        draw(400, 240, 20, 8'hA5, 1, 1'b0, 1'b1, n);
        check("toggle_first", first_pix, pix(400, 220, 8'hA5));
        check("toggle_last", last_pix, pix(400, 260, 8'hA5));

        draw(20, 240, 20, 8'h01, 0, 1'b0, 1'b0, n);
        draw(779, 240, 20, 8'h02, 0, 1'b0, 1'b0, n);
        draw(780, 240, 20, 8'h03, 0, 1'b0, 1'b0, n);
        draw(400, 459, 20, 8'h04, 0, 1'b0, 1'b0, n);
        draw(400, 19, 20, 8'h05, 0, 1'b0, 1'b0, n);

        // Abort part-way through segment 4 (pixels 84..104 of the s=20 cube).
        rmode = 0;
        build(400, 240, 20, 8'h77, oob, n);
        start_req(400, 240, 20, 8'h77, 1'b0);
        wait_pix(90);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_plot_low", plot, 0);
        check("abort_busy_low", busy, 0);
        exp_q.delete();
        d0 = done_cnt; r0 = rej_cnt; p0 = pix_cnt;
        repeat (20) @(negedge clk);
        check("abort_no_done", done_cnt, d0);
        check("abort_no_reject", rej_cnt, r0);
        check("abort_no_more_pixels", pix_cnt, p0);
        draw(300, 200, 12, 8'h88, 0, 1'b0, 1'b0, n);

        // Asynchronous reset mid-draw.
        build(400, 240, 20, 8'h5A, oob, n);
        start_req(400, 240, 20, 8'h5A, 1'b0);
        wait_pix(30);
        #2 reset = 1'b1;
        #1;
        check("arst_ack", ack, 0);
        check("arst_plot", plot, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_reject", reject, 0);
        check("arst_px", px, 0);
        check("arst_py", py, 0);
        check("arst_pcolor", pcolor, 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("idle_after_reset", busy, 0);
        draw(100, 100, 0, 8'hC3, 0, 1'b0, 1'b0, n);

        draw(500, 300, 16, 8'h99, 0, 1'b1, 1'b0, n);
        draw(400, 240, 200, 8'hEE, 2, 1'b0, 1'b0, n);

        for (int k = 0; k < 8; k++) begin
            draw(int'($urandom_range(0, 820)), int'($urandom_range(0, 500)),
                 int'($urandom_range(0, 48)), int'($urandom_range(0, 255)), 2, 1'b0, 1'b0, n);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cube_line_sched.md
CUBE_LINE_SCHED -- requirements
Module: cube_line_sched

Interface
REQ-001 SHALL have parameter SCR_W, default 800, visible width in pixels.
REQ-002 SHALL have parameter SCR_H, default 480, visible height in pixels.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port req, input, 1, draw request, held until ack.
REQ-006 SHALL have port ack, output, 1, one-cycle pulse when the request is latched.
REQ-007 SHALL have port cx, input, 11, cube centre x, sampled at ack.
REQ-008 SHALL have port cy, input, 10, cube centre y, sampled at ack.
REQ-009 SHALL have port size, input, 8, edge half-span s, sampled at ack.
REQ-010 SHALL have port color, input, 8, pixel colour, sampled at ack.
REQ-011 SHALL have port abort, input, 1, cancels the drawing in progress.
REQ-012 SHALL have port pix_ready, input, 1, downstream accepts a pixel this cycle.
REQ-013 SHALL have port plot, output, 1, pixel valid.
REQ-014 SHALL have port px, output, 11, pixel x.
REQ-015 SHALL have port py, output, 10, pixel y.
REQ-016 SHALL have port pcolor, output, 8, pixel colour.
REQ-017 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-018 SHALL have port done, output, 1, one-cycle pulse after the last segment.
REQ-019 SHALL have port reject, output, 1, one-cycle pulse when a request fails bounds.

Function
REQ-020 SHALL use h = s>>1 and vertices V0(cx,cy-s), V1(cx+s,cy-h), V2(cx+s,cy+h), V3(cx,cy+s), V4(cx-s,cy+h), V5(cx-s,cy-h), C(cx,cy).
REQ-021 SHALL draw 9 segments in fixed order: V0-V1, V1-V2, V2-V3, V3-V4, V4-V5, V5-V0, C-V1, C-V5, C-V3.
REQ-022 SHALL use FSM states IDLE, CHECK, LAUNCH, DRAW, FINISH.
REQ-023 IDLE: on req, pulse ack, latch cx/cy/size/color, go to CHECK.
REQ-024 CHECK (1 cycle): if cx<s, cx+s>SCR_W-1, cy<s or cy+s>SCR_H-1, pulse reject and go to IDLE; otherwise set seg=0 and go to LAUNCH.
REQ-025 Bounds arithmetic SHALL be 12-bit unsigned, so no wrap-around.
REQ-026 LAUNCH (1 cycle): drive the segment endpoints and a start pulse to the line engine, then go to DRAW.
REQ-027 DRAW: wait for the engine done pulse.
REQ-028 On engine done in DRAW: if seg==8 go to FINISH, otherwise increment seg and go to LAUNCH.
REQ-029 FINISH: pulse done and go to IDLE.
REQ-030 The line engine SHALL advance only when pix_ready=1 or plot=0.
REQ-031 When plot=1 and pix_ready=0, px, py and pcolor SHALL hold stable.
REQ-032 s=0 SHALL be legal: each segment emits one pixel, 9 pixels in total, duplicates included.
REQ-033 Shared endpoints SHALL be re-plotted; no de-duplication.
REQ-034 abort in any non-IDLE state SHALL force IDLE next cycle, drop plot, and emit no done or reject.
REQ-035 abort in IDLE SHALL be ignored.
REQ-036 If abort and req are both asserted in IDLE, the request SHALL be accepted.
REQ-037 req while busy SHALL be ignored; ack only from IDLE.

Reset
REQ-038 On reset, the FSM SHALL go to IDLE and seg to 0.
REQ-039 On reset, ack, plot, busy, done and reject SHALL be 0.
REQ-040 On reset, px, py, pcolor and the latched request registers SHALL be 0.
REQ-041 Reset SHALL also reset the line engine sub-module.

Structure
REQ-042 Package cube_pkg SHALL hold the state enum, NSEG=9, coordinate widths (X_W=11, Y_W=10) and the vertex/segment index table.
REQ-043 SHALL instantiate one sub-module line_engine.
REQ-044 line_engine SHALL be a Bresenham stepper with ports clk, reset, start, en, x0, y0, x1, y1, plot, x, y, done, internal signed 12-bit error, one pixel per enabled cycle.

Verification
REQ-045 cx=400, cy=240, s=20, pix_ready=1 -> ack, then 9 segments, then done; first pixel (400,220); last pixel (400,260); busy falls with done.
REQ-046 cx=10, cy=240, s=20 -> reject pulse 2 cycles after req; no plot; busy low again after 2 cycles.
REQ-047 s=0 at (100,100) -> exactly 9 plots, all (100,100), then done.
REQ-048 pix_ready toggling every other cycle during s=20 -> pixel sequence identical to REQ-045; held outputs stable while stalled.
REQ-049 abort during segment 4 -> plot=0 and busy=0 next cycle, no done; a new req is then accepted normally.
REQ-050 reset asserted mid-DRAW, asynchronous to clk -> all outputs 0 immediately; FSM in IDLE on release.
